// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM states, default
// lane widths common with the PE/MFU, and saturation limits per width.
package psum_accumulator_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  localparam int unsigned DEF_PROD_W = 16;
  localparam int unsigned DEF_ACC_W  = 24;

  // Largest signed value representable in w bits.
  function automatic longint acc_max(int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint acc_min(int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: adds a sign-extended product to the running sum
// with one guard bit, clamps to the ACC_W signed range and applies ReLU.
module psum_lane
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              relu_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [ACC_W-1:0]  res_o,
  output logic              sat_o
);

  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W + 1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W + 1)'(acc_min(ACC_W));

  logic signed [ACC_W:0] wide;

  assign wide = {acc_i[ACC_W-1], acc_i}
              + {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};

  // Clamp the guard-bit sum into range and flag any clamping.
  always_comb begin
    sat_o = 1'b0;
    sum_o = wide[ACC_W-1:0];
    if (wide > SUM_MAX) begin
      sum_o = SUM_MAX[ACC_W-1:0];
      sat_o = 1'b1;
    end else if (wide < SUM_MIN) begin
      sum_o = SUM_MIN[ACC_W-1:0];
      sat_o = 1'b1;
    end
  end

  assign res_o = (relu_i && sum_o[ACC_W-1]) ? '0 : sum_o;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates MFU_COUNT signed products per beat over a configurable group
// length and emits one saturated (optionally ReLU'd) result vector per group.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned MFU_COUNT = 9,
  parameter int unsigned PROD_W    = DEF_PROD_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CNT_W-1:0]              cfg_len,
  input  logic                          cfg_relu,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MFU_COUNT*PROD_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MFU_COUNT*ACC_W-1:0]    out_data,
  output logic                          out_ovf
);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]             len_q, len_d;
  logic                         relu_q, relu_d;
  logic                         ovf_q, ovf_d;
  logic [ACC_W-1:0]             acc_q [MFU_COUNT];
  logic [ACC_W-1:0]             acc_d [MFU_COUNT];
  logic                         out_valid_q, out_valid_d;
  logic [MFU_COUNT*ACC_W-1:0]   out_data_q, out_data_d;
  logic                         out_ovf_q, out_ovf_d;

  logic                         accept;
  logic                         last_beat;
  logic                         eff_relu;
  logic [CNT_W-1:0]             eff_len;
  logic [CNT_W-1:0]             beat_num;
  logic [ACC_W-1:0]             lane_sum [MFU_COUNT];
  logic [ACC_W-1:0]             lane_res [MFU_COUNT];
  logic [MFU_COUNT-1:0]         lane_sat;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Group parameters come from cfg on the opening beat, from latched copies after.
  // The counter is zero in IDLE, so cnt_q+1 is the beat number in both states.
  always_comb begin
    eff_len   = (state_q == IDLE) ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : len_q;
    eff_relu  = (state_q == IDLE) ? cfg_relu : relu_q;
    beat_num  = cnt_q + CNT_W'(1);
    last_beat = accept && (beat_num == eff_len);
  end

  for (genvar g = 0; g < MFU_COUNT; g++) begin : g_lane
    psum_lane #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .acc_i  (acc_q[g]),
      .prod_i (in_data[g*PROD_W +: PROD_W]),
      .relu_i (eff_relu),
      .sum_o  (lane_sum[g]),
      .res_o  (lane_res[g]),
      .sat_o  (lane_sat[g])
    );
  end

  // Next-state: accumulate on accepted beats, publish and clear on the last one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    relu_d      = relu_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == IDLE) begin
        len_d  = eff_len;
        relu_d = cfg_relu;
      end
      if (last_beat) begin
        state_d     = IDLE;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        out_ovf_d   = ovf_q || (|lane_sat);
        for (int unsigned i = 0; i < MFU_COUNT; i++) begin
          acc_d[i]                      = '0;
          out_data_d[i*ACC_W +: ACC_W]  = lane_res[i];
        end
      end else begin
        state_d = ACCUM;
        cnt_d   = beat_num;
        ovf_d   = ovf_q || (|lane_sat);
        for (int unsigned i = 0; i < MFU_COUNT; i++) begin
          acc_d[i] = lane_sum[i];
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      relu_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < MFU_COUNT; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      relu_q      <= relu_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      for (int unsigned i = 0; i < MFU_COUNT; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and randomized bench for psum_accumulator with a group-level
// reference model (beats collected per group, result computed on completion).
module tb_psum_accumulator;

  localparam int unsigned NL = 9;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 17;
  localparam int unsigned CW = 8;
  localparam longint      SMAX = 65535;
  localparam longint      SMIN = -65536;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CW-1:0]      cfg_len;
  logic               cfg_relu;
  logic               in_valid;
  logic               in_ready;
  logic [NL*PW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NL*AW-1:0]   out_data;
  logic               out_ovf;

  psum_accumulator #(
    .MFU_COUNT (NL),
    .PROD_W    (PW),
    .ACC_W     (AW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               lane_v [NL];
  logic [NL*PW-1:0] grp_beats [$];
  bit               grp_open;
  int               grp_len;
  bit               grp_relu;
  bit               m_ov;
  longint           m_od [NL];
  bit               m_oovf;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic model_clear();
    grp_beats.delete();
    grp_open = 1'b0;
    grp_len  = 0;
    grp_relu = 1'b0;
    m_ov     = 1'b0;
    m_oovf   = 1'b0;
    for (int i = 0; i < NL; i++) m_od[i] = 0;
  endtask

  // Sum each lane over the collected beats, clamping after every addition.
  task automatic finish_group();
    bit ovf = 1'b0;
    for (int i = 0; i < NL; i++) begin
      longint acc = 0;
      foreach (grp_beats[b]) begin
        logic [NL*PW-1:0] bv = grp_beats[b];
        acc = acc + longint'($signed(bv[i*PW +: PW]));
        if (acc > SMAX) begin acc = SMAX; ovf = 1'b1; end
        if (acc < SMIN) begin acc = SMIN; ovf = 1'b1; end
      end
      m_od[i] = (grp_relu && acc < 0) ? 0 : acc;
    end
    m_oovf = ovf;
    m_ov   = 1'b1;
    grp_beats.delete();
    grp_open = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_ovf", 64'(out_ovf), 64'(m_oovf));
      for (int i = 0; i < NL; i++)
        chk($sformatf("out_data[%0d]", i), 64'($signed(out_data[i*AW +: AW])), 64'(m_od[i]));
    end
  endtask

  task automatic set_all(int val);
    for (int i = 0; i < NL; i++) lane_v[i] = val;
  endtask

  // One clock cycle: drive, check in_ready mid-cycle, advance, update model, check outputs.
  task automatic step(bit v, int len, bit relu, bit ordy);
    logic [NL*PW-1:0] d;
    logic [31:0]      lv;
    logic [31:0]      lenv;
    bit               exp_rdy;
    bit               done;
    for (int i = 0; i < NL; i++) begin
      lv = lane_v[i];
      d[i*PW +: PW] = lv[PW-1:0];
    end
    lenv      = len;
    in_valid  = v;
    in_data   = d;
    cfg_len   = lenv[CW-1:0];
    cfg_relu  = relu;
    out_ready = ordy;
    #3;
    exp_rdy = !m_ov || ordy;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    done = 1'b0;
    if (v && exp_rdy) begin
      if (!grp_open) begin
        grp_open = 1'b1;
        grp_len  = (len == 0) ? 1 : len;
        grp_relu = relu;
      end
      grp_beats.push_back(d);
      if (grp_beats.size() == grp_len) begin
        finish_group();
        done = 1'b1;
      end
    end
    if (!done && ordy) m_ov = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_data", 64'(out_data != '0), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_len = '0; cfg_relu = 1'b0; in_data = '0;
    set_all(0);
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Basic accumulate: 3 x 100 -> 300
    set_all(100);
    for (int k = 0; k < 3; k++) step(1, 3, 0, 1);
    set_all(0);
    step(0, 3, 0, 1);

    // ReLU on and off
    for (int r = 1; r >= 0; r--) begin
      set_all(0); lane_v[0] = -5; lane_v[1] = 7;
      step(1, 2, r[0], 1);
      lane_v[1] = 8;
      step(1, 2, r[0], 1);
      step(0, 2, 0, 1);
    end

    // Saturation both directions, then a clean group
    set_all(0); lane_v[0] = 32767; lane_v[1] = -32768;
    for (int k = 0; k < 3; k++) step(1, 3, 0, 1);
    set_all(1);
    for (int k = 0; k < 3; k++) step(1, 3, 0, 1);
    step(0, 3, 0, 1);

    // Backpressure: result held, beats not consumed, ready follows out_ready
    set_all(100);
    for (int k = 0; k < 3; k++) step(1, 3, 0, 1);
    set_all(55);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);

    // Back-to-back single-beat groups with cfg_len = 0
    for (int k = 1; k <= 8; k++) begin
      set_all(k);
      step(1, 0, 0, 1);
    end
    step(0, 0, 0, 1);

    // Reset mid-group discards partial sums
    set_all(50);
    step(1, 4, 0, 1);
    step(1, 4, 0, 1);
    do_reset();
    set_all(10);
    for (int k = 0; k < 4; k++) step(1, 4, 0, 1);
    step(0, 4, 0, 1);

    // Randomized traffic with mid-group config churn and backpressure
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NL; i++)
        lane_v[i] = ($urandom % 2 == 0) ? int'($urandom_range(0, 400)) - 200
                                        : int'($urandom & 32'h0000_FFFF);
      step(($urandom % 4) != 0, int'($urandom_range(0, 4)), bit'($urandom % 2),
           ($urandom % 3) != 0);
    end
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
